// File: rtl/sine_pwm_pkg.sv
// ============================================================================
// Module   : sine_pwm_pkg
// Brief    : Shared constants and helpers for the sine PWM driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sine_pwm_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t PWM_TOP     = 8'd254;
    localparam sample_t RESET_DUTY  = 8'd128;
    localparam sample_t RESET_PHASE = 8'd0;

    // Phase wraps silently modulo 2^SAMPLE_W.
    function automatic sample_t phase_advance(input sample_t cur, input sample_t inc);
        return cur + inc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Emits one tick every divider+1 enabled clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divider,
    output logic             tick
);

    logic [DIV_W-1:0] r_pre_cnt;
    logic             w_reached;

    // >= lets a lowered divider tick immediately instead of wrapping the counter.
    assign w_reached = (r_pre_cnt >= divider);
    assign tick      = en && w_reached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (!en) begin
            r_pre_cnt <= '0;
        end else if (w_reached) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sine_pwm_driver.sv
// ============================================================================
// Module   : sine_pwm_driver
// Brief    : Phase accumulator plus 255-tick PWM fed by an external sine lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sine_pwm_driver
    import sine_pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divider,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] phase,
    output logic             pwm_out,
    output logic             period_start
);

    generate
        if (WIDTH != SAMPLE_W) begin : g_width_check
            $error("sine_pwm_driver supports only WIDTH = 8");
        end
    endgenerate

    logic             w_tick;
    logic             w_boundary;
    logic [WIDTH-1:0] r_pwm_cnt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_step_q;

    pwm_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .divider (divider),
        .tick    (w_tick)
    );

    // w_tick is already gated by en, so en falling wins over a boundary.
    assign w_boundary = w_tick && (r_pwm_cnt == PWM_TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt    <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            r_pwm_cnt    <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= (r_pwm_cnt < r_duty);
            period_start <= w_boundary;
            if (w_tick) begin
                r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + 1'b1;
            end
        end
    end

    // Sample reflects the pre-update phase, so duty lags phase by one period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= RESET_PHASE;
            r_duty   <= RESET_DUTY;
            r_step_q <= '0;
        end else if (w_boundary) begin
            phase    <= phase_advance(phase, r_step_q);
            r_duty   <= sample;
            r_step_q <= step;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sine_pwm_driver.sv
// ============================================================================
// Module   : tb_sine_pwm_driver
// Brief    : Self-checking bench with a sine lookup closing the phase loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sine_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] divider;
    logic [7:0] step;
    logic [7:0] sample;
    logic [7:0] phase;
    logic       pwm_out;
    logic       period_start;

    logic       force_on;
    logic [7:0] force_val;

    int errors = 0;
    int checks = 0;

    // Reference state: phase, duty and latched step as the rules define them.
    int m_phase;
    int m_duty;
    int m_step_q;

    always #5 clk = ~clk;

    sine_pwm_driver #(
        .WIDTH (8),
        .DIV_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .divider      (divider),
        .step         (step),
        .sample       (sample),
        .phase        (phase),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    function automatic logic [7:0] sine_fn(input logic [7:0] p);
        real x;
        x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
        return 8'($rtoi($floor(x + 0.5)));
    endfunction

    assign sample = force_on ? force_val : sine_fn(phase);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_boundary(input int step_at);
        m_duty   = force_on ? int'(force_val) : int'(sine_fn(8'(m_phase)));
        m_phase  = (m_phase + m_step_q) % 256;
        m_step_q = step_at;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_duty   = 128;
        m_step_q = 0;
    endtask

    // One full period from a clean start (pwm_cnt=0, pre_cnt=0).
    task automatic run_period(input int d, input int chg_at, input logic [7:0] new_step,
                              input string tag);
        int p;
        int highs;
        int early;
        int exp_highs;
        p         = 255 * (d + 1);
        highs     = 0;
        early     = 0;
        exp_highs = m_duty * (d + 1);
        divider   = 8'(d);
        for (int i = 1; i <= p; i++) begin
            if (i == chg_at) step = new_step;
            clk1();
            if (pwm_out) highs++;
            if (i < p && period_start) early++;
            if (i == p - 1) chk({tag, "_phase_held"}, 32'(phase), 32'(m_phase));
        end
        chk({tag, "_high_clocks"}, 32'(highs), 32'(exp_highs));
        chk({tag, "_early_start"}, 32'(early), 32'd0);
        model_boundary(int'(step));
        chk({tag, "_period_start"}, 32'(period_start), 32'd1);
        chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
        chk({tag, "_duty"}, 32'(dut.r_duty), 32'(m_duty));
        chk({tag, "_step_q"}, 32'(dut.r_step_q), 32'(m_step_q));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_pwm_out"}, 32'(pwm_out), 32'd0);
        chk({tag, "_period_start"}, 32'(period_start), 32'd0);
        chk({tag, "_duty"}, 32'(dut.r_duty), 32'd128);
        chk({tag, "_pwm_cnt"}, 32'(dut.r_pwm_cnt), 32'd0);
        chk({tag, "_pre_cnt"}, 32'(dut.u_prescaler.r_pre_cnt), 32'd0);
        chk({tag, "_step_q"}, 32'(dut.r_step_q), 32'd0);
    endtask

    initial begin
        int ph0;
        int d;
        int chg;
        logic [7:0] st;
        logic [7:0] vals [3];

        rst       = 1'b1;
        en        = 1'b0;
        divider   = 8'd0;
        step      = 8'd0;
        force_on  = 1'b0;
        force_val = 8'd0;
        model_reset();
        repeat (3) clk1();
        rst = 1'b0;
        clk1();
        check_reset_state("reset");

        // Phase stepping with the sine lookup in the loop.
        step = 8'd64;
        en   = 1'b1;
        repeat (6) run_period(0, 0, 8'd64, "step64");

        // Duty extremes via a forced sample.
        step     = 8'd0;
        force_on = 1'b1;
        vals[0] = 8'd0;
        vals[1] = 8'd255;
        vals[2] = 8'd100;
        for (int k = 0; k < 3; k++) begin
            force_val = vals[k];
            run_period(0, 0, 8'd0, "extreme_load");
            run_period(0, 0, 8'd0, "extreme_run");
        end
        force_on = 1'b0;

        // Randomized divider, step and step-change point.
        for (int k = 0; k < 6; k++) begin
            d   = int'($urandom_range(0, 3));
            st  = 8'($urandom_range(0, 255));
            chg = int'($urandom_range(1, 255 * (d + 1)));
            run_period(d, chg, st, "random");
        end

        // Step 1 -> 7 at pwm_cnt=100.
        step = 8'd1;
        run_period(0, 0, 8'd1, "step1");
        ph0 = int'(phase);
        run_period(0, 101, 8'd7, "stepchg_a");
        chk("stepchg_add_old", 32'((int'(phase) - ph0) & 255), 32'd1);
        ph0 = int'(phase);
        run_period(0, 0, 8'd7, "stepchg_b");
        chk("stepchg_add_new", 32'((int'(phase) - ph0) & 255), 32'd7);

        // Divider 9 -> 2 while pre_cnt=6.
        divider = 8'd9;
        repeat (6) clk1();
        chk("div_pre_cnt6", 32'(dut.u_prescaler.r_pre_cnt), 32'd6);
        chk("div_no_tick_yet", 32'(dut.r_pwm_cnt), 32'd0);
        divider = 8'd2;
        clk1();
        chk("div_immediate_tick", 32'(dut.r_pwm_cnt), 32'd1);
        chk("div_pre_cnt_clear", 32'(dut.u_prescaler.r_pre_cnt), 32'd0);
        repeat (2) clk1();
        chk("div_no_early_tick", 32'(dut.r_pwm_cnt), 32'd1);
        clk1();
        chk("div_tick_3", 32'(dut.r_pwm_cnt), 32'd2);
        repeat (3) clk1();
        chk("div_tick_6", 32'(dut.r_pwm_cnt), 32'd3);
        en = 1'b0;
        clk1();
        chk("div_restart_cnt", 32'(dut.r_pwm_cnt), 32'd0);
        en = 1'b1;
        run_period(0, 0, step, "resume");

        // en toggle at pwm_cnt=200.
        repeat (200) clk1();
        chk("en_cnt200", 32'(dut.r_pwm_cnt), 32'd200);
        en = 1'b0;
        clk1();
        chk("en_off_pwm_out", 32'(pwm_out), 32'd0);
        chk("en_off_pwm_cnt", 32'(dut.r_pwm_cnt), 32'd0);
        chk("en_off_phase", 32'(phase), 32'(m_phase));
        repeat (9) clk1();
        chk("en_off_phase_held", 32'(phase), 32'(m_phase));
        chk("en_off_duty_held", 32'(dut.r_duty), 32'(m_duty));
        en = 1'b1;
        run_period(0, 0, step, "en_restart");

        // en falling on the boundary tick suppresses the update.
        step = 8'd33;
        repeat (254) clk1();
        en = 1'b0;
        clk1();
        chk("enfall_period_start", 32'(period_start), 32'd0);
        chk("enfall_phase", 32'(phase), 32'(m_phase));
        chk("enfall_duty", 32'(dut.r_duty), 32'(m_duty));
        chk("enfall_step_q", 32'(dut.r_step_q), 32'(m_step_q));
        en = 1'b1;
        run_period(0, 0, 8'd33, "enfall_resume");

        // Asynchronous reset mid-period.
        step = 8'd5;
        divider = 8'd3;
        repeat (300) clk1();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        model_reset();
        rst = 1'b0;
        run_period(3, 0, 8'd5, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
